// File: rtl/mpc_pkg.sv
// Shared fixed-point definitions for the MPC/ADMM datapath blocks.
//   W        : signed word width used for data, bounds and residuals
//   fx_t     : W-bit signed word
//   fx_ext_t : W+1-bit signed word, wide enough for a sum of two fx_t
//   ufx_t    : W-bit unsigned word (residual magnitudes)
//   sat_u    : clips a W+1-bit unsigned magnitude to W bits
//   umax     : unsigned maximum of two ufx_t
package mpc_pkg;

    localparam int W = 16;

    typedef logic signed [W-1:0] fx_t;
    typedef logic signed [W:0]   fx_ext_t;
    typedef logic        [W-1:0] ufx_t;

    function automatic ufx_t sat_u(input logic [W:0] a);
        return a[W] ? {W{1'b1}} : a[W-1:0];
    endfunction

    function automatic ufx_t umax(input ufx_t a, input ufx_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slack_update_if.sv
// Knot-point stream bundle for the slack (projection) stage.
//   Input side : in_valid/in_ready with operands u_k, y_k, z_old (group A),
//                x_k, g_k, v_old (group B) and box bounds for both groups.
//   Output side: out_valid/out_ready with z_new, v_new, out_last, plus the
//                per-horizon residual report res_valid/res_max.
// Modport slave is the stage itself; master is the surrounding logic.
interface slack_update_if #(
    parameter int STATE_DIM   = 6,
    parameter int CONTROL_DIM = 12
);
    import mpc_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    fx_t [STATE_DIM-1:0]    u_k, y_k, z_old, u_min, u_max;
    fx_t [CONTROL_DIM-1:0]  x_k, g_k, v_old, x_min, x_max;

    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    fx_t [STATE_DIM-1:0]    z_new;
    fx_t [CONTROL_DIM-1:0]  v_new;
    logic                   res_valid;
    ufx_t                   res_max;

    modport slave (
        input  in_valid, u_k, y_k, z_old, x_k, g_k, v_old,
               u_min, u_max, x_min, x_max, out_ready,
        output in_ready, out_valid, out_last, z_new, v_new, res_valid, res_max
    );

    modport master (
        output in_valid, u_k, y_k, z_old, x_k, g_k, v_old,
               u_min, u_max, x_min, x_max, out_ready,
        input  in_ready, out_valid, out_last, z_new, v_new, res_valid, res_max
    );

endinterface

// File: rtl/box_clamp.sv
// One projection lane: clamps a W+1-bit sum into [lo, hi] and reports the
// magnitude of the change against the previous slack value.
//   sum  : W+1-bit signed sum (cannot have wrapped)
//   lo   : lower bound, hi : upper bound (hi wins when lo > hi)
//   old  : previous slack value of this lane
//   res  : clamped W-bit result
//   absd : |res - old| as W+1-bit unsigned
module box_clamp
    import mpc_pkg::*;
(
    input  fx_ext_t    sum,
    input  fx_t        lo,
    input  fx_t        hi,
    input  fx_t        old,
    output fx_t        res,
    output logic [W:0] absd
);

    fx_ext_t lo_x, hi_x, diff;

    always_comb begin
        lo_x = {lo[W-1], lo};
        hi_x = {hi[W-1], hi};

        // An inverted box collapses onto the upper bound regardless of sum.
        if (lo > hi || sum > hi_x)
            res = hi;
        else if (sum < lo_x)
            res = lo;
        else
            res = sum[W-1:0];

        // Both operands are W-bit, so the difference always fits W+1 bits
        // and its negation cannot overflow.
        diff = {res[W-1], res} - {old[W-1], old};
        absd = diff[W] ? -diff : diff;
    end

endmodule

// File: rtl/slack_update.sv
// ADMM slack stage: z_new = clamp(u + y, u_min, u_max) and
// v_new = clamp(x + g, x_min, x_max) per knot point, plus the max-abs dual
// residual over one horizon.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slack_update_if.slave (input stream, output stream,
//                residual report)
// Two-stage pipeline: S1 holds the widened sums with their bounds and old
// values, S2 holds the clamped results and per-lane residuals. The whole pipe
// advances when S2 is empty or the consumer takes its word.
module slack_update
    import mpc_pkg::*;
#(
    parameter int STATE_DIM   = 6,
    parameter int CONTROL_DIM = 12,
    parameter int HORIZON     = 10
) (
    input  logic           clk,
    input  logic           reset,
    slack_update_if.slave  bus
);

    localparam int NL     = STATE_DIM + CONTROL_DIM;
    localparam int STAGES = 2;
    localparam int CW     = (HORIZON > 1) ? $clog2(HORIZON) : 1;
    localparam logic [CW-1:0] LAST_KNOT = CW'(HORIZON - 1);

    logic [STAGES:1]      vld_pipe;
    logic                 advance;
    logic                 out_fire;

    // Group A occupies lanes [0, STATE_DIM), group B the lanes above it.
    fx_ext_t [NL-1:0]     in_sum;
    fx_t     [NL-1:0]     in_old, in_lo, in_hi;

    fx_ext_t [NL-1:0]     s1_sum;
    fx_t     [NL-1:0]     s1_old, s1_lo, s1_hi;

    fx_t     [NL-1:0]     cl_res;
    logic    [NL-1:0][W:0] cl_absd;

    fx_t     [NL-1:0]     s2_res;
    logic    [NL-1:0][W:0] s2_absd;

    logic [CW-1:0]        cnt;
    ufx_t                 acc, lane_max, acc_next;

    assign advance  = !vld_pipe[STAGES] || bus.out_ready;
    assign out_fire = vld_pipe[STAGES] && bus.out_ready;

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_last  = vld_pipe[STAGES] && (cnt == LAST_KNOT);

    for (genvar l = 0; l < NL; l++) begin : g_lane
        if (l < STATE_DIM) begin : g_a
            assign in_sum[l] = {bus.u_k[l][W-1], bus.u_k[l]}
                             + {bus.y_k[l][W-1], bus.y_k[l]};
            assign in_old[l] = bus.z_old[l];
            assign in_lo[l]  = bus.u_min[l];
            assign in_hi[l]  = bus.u_max[l];
            assign bus.z_new[l] = s2_res[l];
        end else begin : g_b
            assign in_sum[l] = {bus.x_k[l-STATE_DIM][W-1], bus.x_k[l-STATE_DIM]}
                             + {bus.g_k[l-STATE_DIM][W-1], bus.g_k[l-STATE_DIM]};
            assign in_old[l] = bus.v_old[l-STATE_DIM];
            assign in_lo[l]  = bus.x_min[l-STATE_DIM];
            assign in_hi[l]  = bus.x_max[l-STATE_DIM];
            assign bus.v_new[l-STATE_DIM] = s2_res[l];
        end

        box_clamp u_clamp (
            .sum  (s1_sum[l]),
            .lo   (s1_lo[l]),
            .hi   (s1_hi[l]),
            .old  (s1_old[l]),
            .res  (cl_res[l]),
            .absd (cl_absd[l])
        );
    end

    // Pipeline registers. Bounds travel with the knot as well, so a bound
    // change between horizons never mixes with knots still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_sum   <= '0;
            s1_old   <= '0;
            s1_lo    <= '0;
            s1_hi    <= '0;
            s2_res   <= '0;
            s2_absd  <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[1], bus.in_valid};
            if (bus.in_valid) begin
                s1_sum <= in_sum;
                s1_old <= in_old;
                s1_lo  <= in_lo;
                s1_hi  <= in_hi;
            end
            if (vld_pipe[1]) begin
                s2_res  <= cl_res;
                s2_absd <= cl_absd;
            end
        end
    end

    // Residual of the word currently presented; the accumulator is ignored
    // on knot 0 so a new horizon starts fresh.
    always_comb begin
        lane_max = '0;
        for (int l = 0; l < NL; l++)
            lane_max = umax(lane_max, sat_u(s2_absd[l]));
        acc_next = umax((cnt == '0) ? ufx_t'(0) : acc, lane_max);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            acc           <= '0;
            bus.res_max   <= '0;
            bus.res_valid <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            if (out_fire) begin
                acc <= acc_next;
                if (cnt == LAST_KNOT) begin
                    cnt           <= '0;
                    bus.res_max   <= acc_next;
                    bus.res_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
